// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge: valid/ready command stream -> pipelined AHB-Lite single transfers.
// The address slot and the data slot form a two-deep pipeline. The address phase of
// transfer N+1 overlaps the data phase of transfer N. Completions come back in order on a
// one-cycle response strobe.
module ahb_lite_master_bridge #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   // command stream
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // AHB-Lite master
   output logic                  HSEL,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic                  HWRITE,
   output logic [1:0]            HTRANS,
   output logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HREADY,
   // response strobe
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  bridge_idle
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Encoding is {a_vld, d_vld}, so the slot flags read straight off the state bits
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_DATA = 2'b01,
      S_ADDR = 2'b10,
      S_BOTH = 2'b11
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   w_a_vld;
   logic                   w_d_vld;
   logic                   w_accept;
   logic                   w_a_done;
   logic                   w_d_done;

   logic                   r_hsel;
   logic [1:0]             r_htrans;
   logic [ADDR_WIDTH-1:0]  r_haddr;
   logic                   r_hwrite;
   logic                   r_a_write;
   logic [DATA_WIDTH-1:0]  r_a_wdata;
   logic                   r_d_write;
   logic [DATA_WIDTH-1:0]  r_hwdata;
   logic                   r_rsp_valid;
   logic                   r_rsp_write;
   logic [DATA_WIDTH-1:0]  r_rsp_rdata;

   assign w_a_vld  = r_state[1];
   assign w_d_vld  = r_state[0];
   // A pending address phase can only retire when the slave is ready. So a new command
   // may enter only if the slot is empty or is emptying this edge.
   assign w_accept = cmd_valid & cmd_ready;
   assign w_a_done = w_a_vld & HREADY;
   assign w_d_done = w_d_vld & HREADY;

   assign cmd_ready   = ~w_a_vld | HREADY;
   assign bridge_idle = (r_state == S_IDLE);

   assign HSEL      = r_hsel;
   assign HTRANS    = r_htrans;
   assign HADDR     = r_haddr;
   assign HWRITE    = r_hwrite;
   assign HWDATA    = r_hwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;

   // Pipeline occupancy state register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next occupancy: HREADY advances both slots together, and an accept refills the address slot
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: w_state_nxt = w_accept ? S_ADDR : S_IDLE;
         S_ADDR: if (HREADY) w_state_nxt = w_accept ? S_BOTH : S_DATA;
         S_DATA: begin
            if (HREADY) w_state_nxt = w_accept ? S_ADDR : S_IDLE;
            else        w_state_nxt = w_accept ? S_BOTH : S_DATA;
         end
         S_BOTH: if (HREADY) w_state_nxt = w_accept ? S_BOTH : S_DATA;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Address phase: launch NONSEQ on accept, drop to IDLE when the slot frees without refill.
   // HADDR/HWRITE keep their last value while idle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hsel    <= 1'b0;
         r_htrans  <= HTRANS_IDLE;
         r_haddr   <= '0;
         r_hwrite  <= 1'b0;
         r_a_write <= 1'b0;
         r_a_wdata <= '0;
      end else if (w_accept) begin
         r_hsel    <= 1'b1;
         r_htrans  <= HTRANS_NONSEQ;
         r_haddr   <= cmd_addr;
         r_hwrite  <= cmd_write;
         r_a_write <= cmd_write;
         r_a_wdata <= cmd_wdata;
      end else if (w_a_done) begin
         r_hsel    <= 1'b0;
         r_htrans  <= HTRANS_IDLE;
      end
   end

   // Data phase: when the address phase retires, move its direction into the data slot.
   // For a write, also move the write data onto HWDATA.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_d_write <= 1'b0;
         r_hwdata  <= '0;
      end else if (w_a_done) begin
         r_d_write <= r_a_write;
         if (r_a_write) r_hwdata <= r_a_wdata;
      end
   end

   // Response: one-cycle strobe after the data phase completes; read data is captured at that edge
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_d_done;
         if (w_d_done) begin
            r_rsp_write <= r_d_write;
            if (!r_d_write) r_rsp_rdata <= HRDATA;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench: the bridge drives a zero-wait AHB RAM stub whose HREADY can be forced low to stall.
module tb_ahb_lite_master_bridge;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          HSEL;
   logic [AW-1:0] HADDR;
   logic          HWRITE;
   logic [1:0]    HTRANS;
   logic [DW-1:0] HWDATA;
   logic [DW-1:0] HRDATA;
   logic          HREADY;
   logic          rsp_valid;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic          bridge_idle;

   logic          stall = 1'b0;
   int            npass = 0;
   int            ntot = 0;
   int            cyc = 0;

   ahb_lite_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .bridge_idle(bridge_idle)
   );

   always #5 HCLK = ~HCLK;

   // Cycle counter (increments at every rising edge)
   always @(posedge HCLK) cyc <= cyc + 1;

   // RAM slave stub: byte-address indexed words, zero wait unless stalled
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          s_dv;
   logic          s_dw;
   logic [AW-1:0] s_da;
   assign HREADY = ~stall;
   assign HRDATA = (s_dv && !s_dw) ? mem[s_da] : 32'hBAD0BAD0;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s_dv <= 1'b0;
         s_dw <= 1'b0;
         s_da <= '0;
      end else if (HREADY) begin
         s_dv <= HSEL && HTRANS[1];
         s_dw <= HWRITE;
         s_da <= HADDR;
      end
   end

   always @(posedge HCLK)
      if (HRESETn && HREADY && s_dv && s_dw) mem[s_da] <= HWDATA;

   // Monitors: accept cycles and response stream, sampled mid-cycle
   int            acc_cyc[$];
   int            rq_cyc[$];
   logic          rq_write[$];
   logic [DW-1:0] rq_rdata[$];

   always @(negedge HCLK) begin
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
      if (rsp_valid) begin
         rq_cyc.push_back(cyc);
         rq_write.push_back(rsp_write);
         rq_rdata.push_back(rsp_rdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic clr_q();
      acc_cyc.delete();
      rq_cyc.delete();
      rq_write.delete();
      rq_rdata.delete();
   endtask

   // Present a command and return #1 after the edge that accepts it (cmd_valid left high)
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int  n;
      bit  got;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge HCLK);
         if (cmd_ready) got = 1;
         n++;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge HCLK);
      #1;
   endtask

   logic [AW-1:0] b_addr [8];
   logic [DW-1:0] b_data [4];

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      b_addr = '{10'h008, 10'h01F, 10'h00C, 10'h004, 10'h008, 10'h01F, 10'h00C, 10'h004};
      b_data = '{32'h12345678, 32'h88888888, 32'h87654321, 32'h5A5A5A5A};

      // ---- reset values
      #12;
      chk("rst_hsel",   HSEL,        0);
      chk("rst_htrans", HTRANS,      0);
      chk("rst_haddr",  HADDR,       0);
      chk("rst_hwrite", HWRITE,      0);
      chk("rst_hwdata", HWDATA,      0);
      chk("rst_rspv",   rsp_valid,   0);
      chk("rst_rspw",   rsp_write,   0);
      chk("rst_rspd",   rsp_rdata,   0);
      chk("rst_idle",   bridge_idle, 1);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      tick(2);

      // ---- write 0x000 then read 0x000 back to back
      clr_q();
      send(1'b1, 10'h000, 32'hA5A5A5A5);
      chk("wr_hsel",   HSEL,   1);
      chk("wr_htrans", HTRANS, 2'b10);
      chk("wr_haddr",  HADDR,  10'h000);
      chk("wr_hwrite", HWRITE, 1);
      send(1'b0, 10'h000, 32'h0);
      cmd_valid = 1'b0;
      tick(6);
      chk("t1_nrsp", rq_cyc.size(), 2);
      if (rq_cyc.size() == 2 && acc_cyc.size() == 2) begin
         chk("t1_acc_gap", acc_cyc[1] - acc_cyc[0], 1);
         chk("t1_wr_lat",  rq_cyc[0] - acc_cyc[0], 3);
         chk("t1_rd_lat",  rq_cyc[1] - acc_cyc[1], 3);
         chk("t1_wr_dir",  rq_write[0], 1);
         chk("t1_rd_dir",  rq_write[1], 0);
         chk("t1_rd_data", rq_rdata[1], 32'hA5A5A5A5);
      end

      // ---- 4 writes then 4 reads, cmd_valid held throughout
      clr_q();
      for (int i = 0; i < 8; i++)
         send(i < 4, b_addr[i], (i < 4) ? b_data[i] : 32'h0);
      cmd_valid = 1'b0;
      tick(8);
      chk("t2_nacc", acc_cyc.size(), 8);
      chk("t2_nrsp", rq_cyc.size(),  8);
      if (acc_cyc.size() == 8 && rq_cyc.size() == 8) begin
         chk("t2_acc_span", acc_cyc[7] - acc_cyc[0], 7);
         chk("t2_rsp_span", rq_cyc[7] - rq_cyc[0], 7);
         chk("t2_lat0",     rq_cyc[0] - acc_cyc[0], 3);
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_dir%0d", i), rq_write[i], (i < 4) ? 1 : 0);
            if (i >= 4) chk($sformatf("t2_rd%0d", i), rq_rdata[i], b_data[i-4]);
         end
      end

      // ---- read a never-written location
      clr_q();
      send(1'b0, 10'h02F, 32'h0);
      cmd_valid = 1'b0;
      tick(5);
      chk("t3_nrsp", rq_cyc.size(), 1);
      if (rq_cyc.size() == 1) chk("t3_rd_data", rq_rdata[0], 32'h0);

      // ---- 2 wait states during a read data phase, write queued behind it
      clr_q();
      send(1'b0, 10'h008, 32'h0);
      send(1'b1, 10'h030, 32'hDEADBEEF);
      cmd_valid = 1'b0;
      stall = 1'b1;
      for (int s = 0; s < 2; s++) begin
         @(negedge HCLK);
         chk($sformatf("t4_ready%0d", s),  cmd_ready,   0);
         chk($sformatf("t4_hsel%0d", s),   HSEL,        1);
         chk($sformatf("t4_htrans%0d", s), HTRANS,      2'b10);
         chk($sformatf("t4_haddr%0d", s),  HADDR,       10'h030);
         chk($sformatf("t4_hwrite%0d", s), HWRITE,      1);
         chk($sformatf("t4_hwdata%0d", s), HWDATA,      32'h5A5A5A5A);
         chk($sformatf("t4_rspv%0d", s),   rsp_valid,   0);
         chk($sformatf("t4_idle%0d", s),   bridge_idle, 0);
         @(posedge HCLK); #1;
      end
      stall = 1'b0;
      tick(6);
      chk("t4_nrsp", rq_cyc.size(), 2);
      if (rq_cyc.size() == 2 && acc_cyc.size() == 2) begin
         chk("t4_rd_lat",  rq_cyc[0] - acc_cyc[0], 5);
         chk("t4_wr_lat",  rq_cyc[1] - acc_cyc[1], 5);
         chk("t4_rd_data", rq_rdata[0], 32'h12345678);
         chk("t4_wr_dir",  rq_write[1], 1);
      end
      chk("t4_hwdata_after", HWDATA, 32'hDEADBEEF);

      // ---- reset with two transfers in flight
      clr_q();
      send(1'b1, 10'h010, 32'hCAFEF00D);
      send(1'b0, 10'h010, 32'h0);
      cmd_valid = 1'b0;
      HRESETn = 1'b0;
      #1;
      chk("t5_hsel",   HSEL,        0);
      chk("t5_htrans", HTRANS,      0);
      chk("t5_haddr",  HADDR,       0);
      chk("t5_hwrite", HWRITE,      0);
      chk("t5_hwdata", HWDATA,      0);
      chk("t5_rspv",   rsp_valid,   0);
      chk("t5_idle",   bridge_idle, 1);
      tick(2);
      HRESETn = 1'b1;
      tick(6);
      chk("t5_no_rsp", rq_cyc.size(), 0);
      clr_q();
      send(1'b1, 10'h010, 32'h13579BDF);
      send(1'b0, 10'h010, 32'h0);
      cmd_valid = 1'b0;
      tick(6);
      chk("t5_nrsp", rq_cyc.size(), 2);
      if (rq_cyc.size() == 2) begin
         chk("t5_wr_dir",  rq_write[0], 1);
         chk("t5_rd_data", rq_rdata[1], 32'h13579BDF);
      end

      // ---- idle for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge HCLK);
         chk($sformatf("t6_htrans%0d", i), HTRANS,      0);
         chk($sformatf("t6_hsel%0d", i),   HSEL,        0);
         chk($sformatf("t6_idle%0d", i),   bridge_idle, 1);
         chk($sformatf("t6_rspv%0d", i),   rsp_valid,   0);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
